regfile_wb_arbiter: RTL and testbench

//   Shares the register file's single synchronous write port among NUM_REQ writeback

---
 rtl/ember_rf_pkg.sv | 40 ++++
 rtl/regfile_wb_arbiter_rr_pick.sv | 50 +++++
 rtl/regfile_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ember_rf_pkg.sv
// Shared register-file constants, address typedef and writeback classification
// helper for the ember core's register file and its writeback arbiter.
package ember_rf_pkg;

  // Default register-file geometry
  localparam int DATA_W     = 64;
  localparam int REG_ADDR_W = 6;
  localparam int NUM_REGS   = 34;

  // Architected register numbers
  localparam int REG_NULL = 0;   // writes are discarded, reads return zero
  localparam int REG_SF   = 31;  // status flags
  localparam int REG_LR   = 32;  // link register
  localparam int REG_SP   = 33;  // stack pointer

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // What the write port does with an accepted writeback
  typedef enum logic [1:0] {
    WB_WRITE = 2'd0,  // real register: drive the write port
    WB_NULL  = 2'd1,  // NULL register: swallow silently
    WB_RANGE = 2'd2   // no such register: swallow and flag
  } wb_class_e;

  // Classify a destination address. Addresses are widened to int so that the
  // same helper serves any REG_ADDR_W / NUM_REGS override.
  function automatic wb_class_e wb_classify(input int unsigned addr,
                                            input int unsigned num_regs);
    wb_class_e cls;
    if (addr == REG_NULL) begin
      cls = WB_NULL;
    end else if (addr >= num_regs) begin
      cls = WB_RANGE;
    end else begin
      cls = WB_WRITE;
    end
    return cls;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority picker. Starting at rr_ptr and
// wrapping modulo N, the first set bit of valid wins. Produces a one-hot grant,
// the encoded winner index and an any-valid flag. N need not be a power of two.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     valid,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any_valid
);

  // w_rot_idx[k] is the requester index that sits k places after rr_ptr
  logic [PTR_W-1:0] w_rot_idx [N];
  logic [N-1:0]     w_rot_valid;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      logic [PTR_W:0] w_sum;
      // One spare bit so rr_ptr + offset cannot overflow before the wrap test
      assign w_sum = {1'b0, rr_ptr} + (PTR_W+1)'(gi);
      assign w_rot_idx[gi] = (w_sum >= (PTR_W+1)'(N))
                             ? PTR_W'(w_sum - (PTR_W+1)'(N))
                             : w_sum[PTR_W-1:0];
      assign w_rot_valid[gi] = valid[w_rot_idx[gi]];
    end
  endgenerate

  assign any_valid = |w_rot_valid;

  // Walk the rotated vector from the far end so the nearest valid entry wins
  always_comb begin
    grant_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot_valid[k]) begin
        grant_idx = w_rot_idx[k];
      end
    end
  end

  generate
    for (gi = 0; gi < N; gi++) begin : g_grant
      assign grant[gi] = any_valid && (grant_idx == PTR_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter that shares the register file's
// single synchronous write port among NUM_REQ writeback requesters.
// The winning write is registered onto wr_en/wr1_addr/wr1_data one cycle after
// acceptance. Writes to NULL are swallowed; writes beyond NUM_REGS are swallowed
// and flagged on drop_err. Either way the requester is released that cycle.
// Optional build macro WB_BYPASS_EN adds a combinational write-to-read bypass
// for two read ports, so readers see the value being written this cycle.
module regfile_wb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = ember_rf_pkg::DATA_W,
  parameter int REG_ADDR_W = ember_rf_pkg::REG_ADDR_W,
  parameter int NUM_REGS   = ember_rf_pkg::NUM_REGS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic                          wr_en,
  output logic [REG_ADDR_W-1:0]         wr1_addr,
  output logic [DATA_W-1:0]             wr1_data,
  output logic                          drop_err
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0]         rd1_addr,
  input  logic [REG_ADDR_W-1:0]         rd2_addr,
  input  logic [DATA_W-1:0]             rf_rd1,
  input  logic [DATA_W-1:0]             rf_rd2,
  output logic [DATA_W-1:0]             byp_rd1,
  output logic [DATA_W-1:0]             byp_rd2
`endif
);

  import ember_rf_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Round-robin pointer: the requester that has highest priority next cycle
  logic [PTR_W-1:0]      r_rr_ptr;

  // Registered write-port state
  logic                  r_wr_en;
  logic [REG_ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0]     r_wr_data;
  logic                  r_drop_err;

  // Picker results
  logic [NUM_REQ-1:0]    w_grant;
  logic [PTR_W-1:0]      w_grant_idx;
  logic                  w_any_valid;

  // Winner's unpacked request and its fate
  logic [REG_ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0]     w_win_data;
  wb_class_e             w_win_class;
  logic                  w_xfer;
  logic                  w_do_write;
  logic                  w_do_drop;
  logic [PTR_W-1:0]      w_ptr_next;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .valid     (req_valid),
    .rr_ptr    (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .any_valid (w_any_valid)
  );

  // Ready follows the grant directly; nothing is accepted while in reset
  assign req_ready = rst ? '0 : w_grant;

  // A transfer happens whenever some requester is valid outside reset,
  // including NULL and out-of-range writes (they are accepted, then dropped)
  assign w_xfer = w_any_valid && !rst;

  // Select the winner's address and data out of the packed request buses
  always_comb begin
    w_win_addr = '0;
    w_win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant_idx == PTR_W'(k)) begin
        w_win_addr = req_addr[k*REG_ADDR_W +: REG_ADDR_W];
        w_win_data = req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_win_class = wb_classify(32'(w_win_addr), NUM_REGS);
  assign w_do_write  = w_xfer && (w_win_class == WB_WRITE);
  assign w_do_drop   = w_xfer && (w_win_class == WB_RANGE);

  // Pointer moves just past the winner, wrapping at NUM_REQ
  assign w_ptr_next = (w_grant_idx == PTR_W'(NUM_REQ - 1))
                      ? '0
                      : w_grant_idx + 1'b1;

  // Advance the round-robin pointer only on an accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= w_ptr_next;
    end
  end

  // Write enable and drop flag are single-cycle pulses, recomputed every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en    <= 1'b0;
      r_drop_err <= 1'b0;
    end else begin
      r_wr_en    <= w_do_write;
      r_drop_err <= w_do_drop;
    end
  end

  // Address/data only load on a real write, otherwise they keep the last write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_do_write) begin
      r_wr_addr <= w_win_addr;
      r_wr_data <= w_win_data;
    end
  end

  assign wr_en    = r_wr_en;
  assign wr1_addr = r_wr_addr;
  assign wr1_data = r_wr_data;
  assign drop_err = r_drop_err;

`ifdef WB_BYPASS_EN
  logic w_byp1_hit;
  logic w_byp2_hit;

  assign w_byp1_hit = r_wr_en && (rd1_addr == r_wr_addr) && (rd1_addr != '0);
  assign w_byp2_hit = r_wr_en && (rd2_addr == r_wr_addr) && (rd2_addr != '0);

  // Forward the in-flight write to readers of the same register
  always_comb begin
    byp_rd1 = rf_rd1;
    byp_rd2 = rf_rd2;
    if (w_byp1_hit) begin
      byp_rd1 = r_wr_data;
    end
    if (w_byp2_hit) begin
      byp_rd2 = r_wr_data;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural arbitration model.
// Build with WB_BYPASS_EN defined to also exercise the read bypass.
module tb_regfile_wb_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int AW = 6;
  localparam int NR = 34;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic            wr_en;
  logic [AW-1:0]   wr1_addr;
  logic [DW-1:0]   wr1_data;
  logic            drop_err;
`ifdef WB_BYPASS_EN
  logic [AW-1:0]   rd1_addr = '0;
  logic [AW-1:0]   rd2_addr = '0;
  logic [DW-1:0]   rf_rd1   = '0;
  logic [DW-1:0]   rf_rd2   = '0;
  logic [DW-1:0]   byp_rd1;
  logic [DW-1:0]   byp_rd2;
`endif

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .NUM_REQ    (N),
    .DATA_W     (DW),
    .REG_ADDR_W (AW),
    .NUM_REGS   (NR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wr_en     (wr_en),
    .wr1_addr  (wr1_addr),
    .wr1_data  (wr1_data),
    .drop_err  (drop_err)
`ifdef WB_BYPASS_EN
    ,
    .rd1_addr  (rd1_addr),
    .rd2_addr  (rd2_addr),
    .rf_rd1    (rf_rd1),
    .rf_rd2    (rf_rd2),
    .byp_rd1   (byp_rd1),
    .byp_rd2   (byp_rd2)
`endif
  );

  // Requester-side stimulus state
  logic [N-1:0]  v;
  logic [AW-1:0] a [N];
  logic [DW-1:0] d [N];

  // Reference model state: expected registered outputs for the coming cycle
  int            m_ptr;
  logic          m_wr_en;
  logic          m_drop;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit            m_known;
  logic [DW-1:0] rf_exp [NR];
  logic [DW-1:0] rf_dut [NR];

  int            n_vec;
  int            n_miss;
  logic [N-1:0]  obs_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check, then advance the model to the next edge
  task automatic cycle(input logic r);
    int win;
    int idx;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    rst       = r;
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = a[i];
      req_data[i*DW +: DW] = d[i];
    end
    #1;
    chk("wr_en", 64'(wr_en), 64'(m_wr_en));
    chk("drop_err", 64'(drop_err), 64'(m_drop));
    if (m_known) begin
      chk("wr1_addr", 64'(wr1_addr), 64'(m_addr));
      chk("wr1_data", wr1_data, m_data);
    end
    if (wr_en === 1'b1 && wr1_addr < AW'(NR)) begin
      rf_dut[wr1_addr] = wr1_data;
    end
    // Winner: first valid requester at or after the pointer, wrapping
    win = -1;
    if (!r) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (win < 0 && v[idx]) win = idx;
      end
    end
    exp_ready = (win >= 0) ? N'(1 << win) : '0;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    obs_ready = req_ready;
    if (r) begin
      m_wr_en = 1'b0; m_drop = 1'b0; m_addr = '0; m_data = '0;
      m_known = 1'b1; m_ptr = 0;
    end else if (win >= 0) begin
      m_ptr = (win + 1) % N;
      if (a[win] == 0) begin
        m_wr_en = 1'b0; m_drop = 1'b0; m_known = 1'b0;
      end else if (int'(a[win]) >= NR) begin
        m_wr_en = 1'b0; m_drop = 1'b1; m_known = 1'b0;
      end else begin
        m_wr_en = 1'b1; m_drop = 1'b0; m_known = 1'b1;
        m_addr  = a[win]; m_data = d[win];
        rf_exp[a[win]] = d[win];
      end
      v[win] = 1'b0;
    end else begin
      m_wr_en = 1'b0; m_drop = 1'b0;
    end
  endtask

  initial begin
    int sel;
    logic r;
    n_vec = 0;
    n_miss = 0;
    v = '0;
    for (int i = 0; i < N; i++) begin
      a[i] = '0;
      d[i] = '0;
    end
    for (int i = 0; i < NR; i++) begin
      rf_exp[i] = '0;
      rf_dut[i] = '0;
    end
    rst = 1'b1;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    repeat (2) @(posedge clk);
    m_ptr = 0; m_wr_en = 1'b0; m_drop = 1'b0;
    m_addr = '0; m_data = '0; m_known = 1'b1;

    // Reset state: outputs cleared, no ready while rst=1 even with all valid
    v = 4'hF;
    cycle(1'b1);
    chk("rst_ready", 64'(obs_ready), 64'd0);
    v = '0;

    // 1. Single requester
    v = 4'b0010; a[1] = 6'd5; d[1] = 64'hA5;
    cycle(1'b0);
    chk("t1_ready", 64'(obs_ready), 64'b0010);
    cycle(1'b0);
    chk("t1_wr_en", 64'(wr_en), 64'd1);
    chk("t1_addr", 64'(wr1_addr), 64'd5);
    chk("t1_data", wr1_data, 64'hA5);

    // 2. All valid continuously from rr_ptr=0
    cycle(1'b1);
    for (int i = 0; i < N; i++) begin
      a[i] = AW'(10 + i);
      d[i] = 64'(100 + i);
    end
    for (int s = 0; s < 5; s++) begin
      v = 4'hF;
      cycle(1'b0);
      chk("t2_grant", 64'(obs_ready), 64'(1 << (s % N)));
      if (s > 0) chk("t2_wr_en", 64'(wr_en), 64'd1);
    end
    v = '0;

    // 3. NULL write, then out-of-range write
    v = 4'b0100; a[2] = 6'd0; d[2] = 64'h1234;
    cycle(1'b0);
    chk("t3_null_ready", 64'(obs_ready), 64'b0100);
    cycle(1'b0);
    chk("t3_null_wr_en", 64'(wr_en), 64'd0);
    chk("t3_null_drop", 64'(drop_err), 64'd0);
    v = 4'b0100; a[2] = 6'd40;
    cycle(1'b0);
    chk("t3_oor_ready", 64'(obs_ready), 64'b0100);
    cycle(1'b0);
    chk("t3_oor_wr_en", 64'(wr_en), 64'd0);
    chk("t3_oor_drop", 64'(drop_err), 64'd1);
    cycle(1'b0);
    chk("t3_drop_pulse", 64'(drop_err), 64'd0);

    // 4. Reset while req0 and req3 are valid; pointer returns to 0
    v = 4'b0001; a[0] = 6'd3; d[0] = 64'h33;
    cycle(1'b0);
    a[3] = 6'd4; d[3] = 64'h44;
    v = 4'b1001;
    cycle(1'b1);
    chk("t4_rst_ready", 64'(obs_ready), 64'd0);
    cycle(1'b0);
    chk("t4_rst_wr_en", 64'(wr_en), 64'd0);
    chk("t4_first", 64'(obs_ready), 64'b0001);
    cycle(1'b0);
    chk("t4_second", 64'(obs_ready), 64'b1000);
    v = '0;

    // 5. Same address from two requesters: round-robin order, last writer wins
    cycle(1'b1);
    v = 4'b0011; a[0] = 6'd33; d[0] = 64'd1; a[1] = 6'd33; d[1] = 64'd2;
    cycle(1'b0);
    chk("t5_g0", 64'(obs_ready), 64'b0001);
    cycle(1'b0);
    chk("t5_g1", 64'(obs_ready), 64'b0010);
    chk("t5_w1_addr", 64'(wr1_addr), 64'd33);
    chk("t5_w1_data", wr1_data, 64'd1);
    cycle(1'b0);
    chk("t5_w2_addr", 64'(wr1_addr), 64'd33);
    chk("t5_w2_data", wr1_data, 64'd2);
    chk("t5_sp", rf_dut[33], 64'd2);
    chk("t5_sp_model", rf_dut[33], rf_exp[33]);

`ifdef WB_BYPASS_EN
    // 6. Bypass of the in-flight write
    v = 4'b0001; a[0] = 6'd7; d[0] = 64'h55;
    cycle(1'b0);
    rd1_addr = 6'd7; rf_rd1 = 64'h11;
    rd2_addr = 6'd0; rf_rd2 = 64'h22;
    cycle(1'b0);
    chk("t6_byp1", byp_rd1, 64'h55);
    chk("t6_byp2", byp_rd2, 64'h22);
    rd1_addr = 6'd8;
    #1;
    chk("t6_nohit", byp_rd1, 64'h11);
`endif

    // Randomized traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i] = 1'b1;
          sel = int'($urandom_range(0, 9));
          if (sel == 0)      a[i] = '0;
          else if (sel == 1) a[i] = AW'($urandom_range(NR, (1 << AW) - 1));
          else               a[i] = AW'($urandom_range(1, NR - 1));
          d[i] = {$urandom, $urandom};
        end
      end
      r = ($urandom_range(0, 99) == 0);
      cycle(r);
    end
    v = '0;
    repeat (3) cycle(1'b0);
    for (int i = 0; i < NR; i++) begin
      chk("rf_final", rf_dut[i], rf_exp[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
